// File: rtl/mcp3008_pkg.sv
// Shared definitions for the MCP3008 scan sequencer: frame geometry of the
// MCP3008 single-ended read command, rail codes and the state encodings used
// by the scan FSM and the per-conversion SPI engine.
package mcp3008_pkg;

  localparam int FRAME_SCLKS = 17;            // SCLK periods per conversion frame
  localparam int CMD_BITS    = 5;             // start, SGL, D2, D1, D0
  localparam int DATA_FIRST  = 8;             // first SCLK period carrying B9
  localparam int FRAME_HP    = 2 * FRAME_SCLKS;
  localparam logic [9:0] RAIL_LO = 10'h000;
  localparam logic [9:0] RAIL_HI = 10'h3FF;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONVERT,
    S_STORE,
    S_DONE
  } scan_state_t;

  typedef enum logic [1:0] {
    X_IDLE,
    X_SETUP,
    X_SHIFT,
    X_HOLD
  } xfer_phase_t;

  function automatic logic is_rail(input logic [9:0] raw);
    return (raw == RAIL_LO) || (raw == RAIL_HI);
  endfunction

endpackage

// File: rtl/mcp3008_spi_xfer.sv
// One MCP3008 single-ended conversion over SPI mode 0,0.
// Frame: CS_SETUP (1 half-period, MOSI = start bit), SHIFT (17 SCLK periods,
// command bits out on falling edges, B9..B0 in on rising edges of periods
// 8..17), CS_HOLD (T_CSH half-periods with CS high). done pulses in the last
// cycle of CS_HOLD, so a conversion occupies (35+T_CSH)*CLK_DIV cycles
// counted from the cycle after go.
// Ports:
//   clk, rst_n     clock, async active-low reset
//   go             start a conversion (accepted only while idle)
//   ch             channel latched with go
//   busy           conversion in progress
//   done           one-cycle pulse, raw valid
//   raw            10-bit result
//   spi_*          MCP3008 pins
module mcp3008_spi_xfer
  import mcp3008_pkg::*;
#(
  parameter int CLK_DIV = 25,
  parameter int T_CSH   = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       go,
  input  logic [2:0] ch,
  output logic       busy,
  output logic       done,
  output logic [9:0] raw,
  input  logic       spi_miso_i,
  output logic       spi_mosi_o,
  output logic       spi_sclk_o,
  output logic       spi_cs_n_o
);

  localparam int DW     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int HP_MAX = (FRAME_HP > T_CSH) ? FRAME_HP : T_CSH;
  localparam int HW     = $clog2(HP_MAX + 1);

  xfer_phase_t             phase;
  logic [DW-1:0]           div_cnt;
  logic [HW-1:0]           hp;      // half-period index in SHIFT, gap count in HOLD
  logic [CMD_BITS-2:0]     cmd;     // bits still to drive after the start bit
  logic                    tick;

  assign tick = (div_cnt == DW'(CLK_DIV - 1));
  assign busy = (phase != X_IDLE);
  assign done = (phase == X_HOLD) && tick && (hp == HW'(T_CSH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase      <= X_IDLE;
      div_cnt    <= '0;
      hp         <= '0;
      cmd        <= '0;
      raw        <= '0;
      spi_cs_n_o <= 1'b1;
      spi_sclk_o <= 1'b0;
      spi_mosi_o <= 1'b0;
    end else begin
      if (phase == X_IDLE || tick) div_cnt <= '0;
      else                         div_cnt <= div_cnt + 1'b1;

      case (phase)
        X_IDLE: if (go) begin
          phase      <= X_SETUP;
          spi_cs_n_o <= 1'b0;
          spi_mosi_o <= 1'b1;               // start bit
          cmd        <= {1'b1, ch};         // SGL, D2, D1, D0
          raw        <= '0;
        end
        X_SETUP: if (tick) begin
          phase      <= X_SHIFT;
          hp         <= '0;
          spi_sclk_o <= 1'b1;               // rising edge of period 1
        end
        X_SHIFT: if (tick) begin
          if (hp == HW'(FRAME_HP - 1)) begin
            phase      <= X_HOLD;
            hp         <= '0;
            spi_cs_n_o <= 1'b1;
            spi_mosi_o <= 1'b0;
          end else begin
            hp <= hp + 1'b1;
            if (!hp[0]) begin
              // high half ends: falling edge, present next command bit
              spi_sclk_o <= 1'b0;
              spi_mosi_o <= cmd[CMD_BITS-2];
              cmd        <= {cmd[CMD_BITS-3:0], 1'b0};
            end else begin
              // low half ends: rising edge; data periods start at hp 2*(DATA_FIRST-1)
              spi_sclk_o <= 1'b1;
              if (hp >= HW'(2 * DATA_FIRST - 3))
                raw <= {raw[8:0], spi_miso_i};
            end
          end
        end
        X_HOLD: if (tick) begin
          if (hp == HW'(T_CSH - 1)) phase <= X_IDLE;
          else                      hp    <= hp + 1'b1;
        end
        default: phase <= X_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/adc_scan_sequencer.sv
// Scans MCP3008 channels 0..N_CH-1, scales each 10-bit code to raw[9:2] and
// publishes the whole set at once together with per-channel rail flags.
// Scans are requested by start_i or by the periodic auto timer; a request
// seen while a scan runs is held in a 1-deep pending flag and launched
// straight out of DONE.
// Ports:
//   clk, rst_n       clock, async active-low reset
//   ena              gates acceptance of new requests (never aborts a scan)
//   start_i          scan request pulse
//   auto_en_i        enables the SCAN_PERIOD auto-trigger timer
//   spi_*            MCP3008 pins
//   samples_o        channel k at [8k+7:8k]
//   rail_fault_o     bit k set when channel k's code was 0 or 1023
//   scan_valid_o     one-cycle pulse, samples_o/rail_fault_o coherent
//   busy_o           scan accepted and not yet completed
module adc_scan_sequencer
  import mcp3008_pkg::*;
#(
  parameter int CLK_DIV     = 25,
  parameter int N_CH        = 4,
  parameter int SCAN_PERIOD = 50000000,
  parameter int T_CSH       = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              start_i,
  input  logic              auto_en_i,
  input  logic              spi_miso_i,
  output logic              spi_mosi_o,
  output logic              spi_sclk_o,
  output logic              spi_cs_n_o,
  output logic [N_CH*8-1:0] samples_o,
  output logic [N_CH-1:0]   rail_fault_o,
  output logic              scan_valid_o,
  output logic              busy_o
);

  localparam int TW = (SCAN_PERIOD > 1) ? $clog2(SCAN_PERIOD) : 1;

  scan_state_t              state, state_nxt;
  logic [2:0]               ch, ch_nxt;
  logic                     pending;
  logic [TW-1:0]            timer;
  logic                     auto_req, req, last_ch, go;
  logic [N_CH-1:0][9:0]     shadow;
  logic                     x_busy, x_done;
  logic [9:0]               x_raw;

  assign auto_req = auto_en_i && (timer == TW'(SCAN_PERIOD - 1));
  assign req      = ena && (start_i || auto_req);
  assign last_ch  = (ch == 3'(N_CH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                             timer <= '0;
    else if (!auto_en_i || auto_req)        timer <= '0;
    else                                    timer <= timer + 1'b1;
  end

  // go is raised on the transition into CONVERT so the frame starts in the
  // first CONVERT cycle; the engine latches ch_nxt with it.
  always_comb begin
    state_nxt    = state;
    ch_nxt       = ch;
    go           = 1'b0;
    scan_valid_o = 1'b0;
    busy_o       = 1'b0;
    case (state)
      S_IDLE: if (req && !x_busy) begin
        state_nxt = S_CONVERT;
        ch_nxt    = '0;
        go        = 1'b1;
      end
      S_CONVERT: begin
        busy_o = 1'b1;
        if (x_done) state_nxt = S_STORE;
      end
      S_STORE: begin
        busy_o = 1'b1;
        if (last_ch) state_nxt = S_DONE;
        else begin
          state_nxt = S_CONVERT;
          ch_nxt    = ch + 3'd1;
          go        = 1'b1;
        end
      end
      S_DONE: begin
        scan_valid_o = 1'b1;
        // a queued or same-cycle request chains into the next scan, so busy
        // stays up across the seam
        if (pending || req) begin
          state_nxt = S_CONVERT;
          ch_nxt    = '0;
          go        = 1'b1;
          busy_o    = 1'b1;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      ch           <= '0;
      pending      <= 1'b0;
      shadow       <= '0;
      samples_o    <= '0;
      rail_fault_o <= '0;
    end else begin
      state <= state_nxt;
      ch    <= ch_nxt;

      if (state == S_DONE)                 pending <= 1'b0;
      else if (state != S_IDLE && req)     pending <= 1'b1;

      if (state == S_CONVERT && x_done) begin
        for (int k = 0; k < N_CH; k++)
          if (ch == 3'(k)) shadow[k] <= x_raw;
      end

      // publish on entry to DONE so the set is visible alongside scan_valid
      if (state == S_STORE && last_ch) begin
        for (int k = 0; k < N_CH; k++) begin
          samples_o[8*k +: 8] <= shadow[k][9:2];
          rail_fault_o[k]     <= is_rail(shadow[k]);
        end
      end
    end
  end

  mcp3008_spi_xfer #(
    .CLK_DIV (CLK_DIV),
    .T_CSH   (T_CSH)
  ) u_xfer (
    .clk        (clk),
    .rst_n      (rst_n),
    .go         (go),
    .ch         (ch_nxt),
    .busy       (x_busy),
    .done       (x_done),
    .raw        (x_raw),
    .spi_miso_i (spi_miso_i),
    .spi_mosi_o (spi_mosi_o),
    .spi_sclk_o (spi_sclk_o),
    .spi_cs_n_o (spi_cs_n_o)
  );

endmodule
